// File: rtl/des_key_schedule.sv
// DES round subkey generator: PC-1 load, per-round C/D rotation, PC-2 output.
// One 48-bit subkey per valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        mode,
    input  logic        start,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);
    typedef enum logic {IDLE, GEN} state_t;

    // FIPS 46-3 tables, entries are 1-based DES bit numbers of the source.
    localparam logic [5:0] PC1 [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };
    localparam logic [5:0] PC2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // DES bit n lives at vector index W-n, so the table walk shifts in MSB first.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        logic [5:0]  idx;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            idx = 6'd0 - PC1[i];
            o   = {o[54:0], k[idx]};
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        logic [5:0]  idx;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            idx = 6'd56 - PC2[i];
            o   = {o[46:0], cd[idx]};
        end
        return o;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Shift schedule: rounds 1, 2, 9 and 16 shift by one, all others by two.
    function automatic logic shift_two(input logic [4:0] s);
        return !(s == 5'd1 || s == 5'd2 || s == 5'd9 || s == 5'd16);
    endfunction

    state_t      state_q;
    logic [27:0] c_q, d_q, c_d, d_d;
    logic [3:0]  round_q;
    logic        mode_q, busy_q, valid_q, done_q;
    logic [55:0] pc1_key;
    logic [4:0]  sh_idx;
    logic        two;

    always_comb begin
        pc1_key = pc1(key_in);
        sh_idx  = mode_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
        two     = shift_two(sh_idx);
        c_d     = mode_q ? rotr(c_q, two) : rotl(c_q, two);
        d_d     = mode_q ? rotr(d_q, two) : rotl(d_q, two);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    // Decrypt starts from C0/D0 unrotated: 28 total shifts make C16 == C0.
                    mode_q  <= mode;
                    c_q     <= mode ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
                    d_q     <= mode ? pc1_key[27:0]  : rotl(pc1_key[27:0], 1'b0);
                    round_q <= '0;
                    busy_q  <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= GEN;
                end
                GEN: if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_q <= IDLE;
                        round_q <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                        c_q     <= c_d;
                        d_q     <= d_d;
                    end
                end
            endcase
        end
    end

    assign subkey       = pc2({c_q, d_q});
    assign subkey_valid = valid_q;
    assign round        = round_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: a cumulative-shift DES key model feeds an
// expectation queue, a negedge monitor pops on every handshake and checks stall stability.
module tb_des_key_schedule;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b1;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    des_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .mode(mode), .start(start),
        .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .round(round), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int PC1T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                      19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                      14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int PC2T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int SH [16]   = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct packed {
        logic [3:0]  rd;
        logic [47:0] sk;
    } exp_t;

    exp_t        q[$];
    logic [47:0] ks [1:16];
    int          total = 0;
    int          bad = 0;
    int          acc_cnt = 0;
    bit          rand_rdy = 1'b0;
    int          stall = 0;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Kn = PC-2 of C0/D0 rotated left by the cumulative shift count.
    task automatic build(input logic [63:0] key);
        bit cd [56];
        bit cr [56];
        int tot;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[i] = key[64 - PC1T[i]];
        tot = 0;
        for (int n = 1; n <= 16; n++) begin
            tot += SH[n-1];
            for (int i = 0; i < 28; i++) begin
                cr[i]      = cd[(i + tot) % 28];
                cr[28 + i] = cd[28 + (i + tot) % 28];
            end
            k = '0;
            for (int j = 0; j < 48; j++) k[47-j] = cr[PC2T[j] - 1];
            ks[n] = k;
        end
    endtask

    task automatic push_exp(input logic m);
        exp_t e;
        for (int r = 0; r < 16; r++) begin
            e.rd = 4'(r);
            e.sk = m ? ks[16 - r] : ks[r + 1];
            q.push_back(e);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rand_rdy) subkey_ready = 1'b1;
        else if (stall > 0) begin
            subkey_ready = 1'b0;
            stall--;
        end else begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                stall = 4;
                subkey_ready = 1'b0;
            end else subkey_ready = (r > 3);
        end
    end

    bit          have_hold = 1'b0;
    logic [47:0] hold_sk;
    logic [3:0]  hold_rd;
    always @(negedge clk) begin
        exp_t e;
        if (have_hold && subkey_valid) begin
            chk("stall_subkey", 64'(subkey), 64'(hold_sk));
            chk("stall_round", 64'(round), 64'(hold_rd));
        end
        if (subkey_valid && subkey_ready) begin
            acc_cnt++;
            if (q.size() == 0) chk("extra_accept", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                chk("subkey", 64'(subkey), 64'(e.sk));
                chk("round", 64'(round), 64'(e.rd));
            end
        end
        have_hold = subkey_valid && !subkey_ready;
        hold_sk   = subkey;
        hold_rd   = round;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Runs one schedule with key k, expecting subkeys of model key mk.
    task automatic run(input logic [63:0] k, input logic [63:0] mk, input logic m,
                       input bit nostall, input bit inject,
                       output logic [47:0] fsk, output logic [47:0] lsk);
        int busy_cyc, base, n;
        bit seen_done, injected;
        build(mk);
        wait_idle();
        @(posedge clk);
        #1;
        push_exp(m);
        base = acc_cnt;
        key_in = k;
        mode = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        fsk = subkey;
        chk("first_valid", 64'(subkey_valid), 64'd1);
        chk("first_round", 64'(round), 64'd0);
        chk("first_busy", 64'(busy), 64'd1);
        busy_cyc = busy ? 1 : 0;
        seen_done = 1'b0;
        injected = 1'b0;
        n = 0;
        while (!seen_done && n < 2000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (inject && !injected && subkey_valid && round == 4'd7) begin
                key_in = ~k;
                mode = ~m;
                start = 1'b1;
                injected = 1'b1;
            end
            if (busy) busy_cyc++;
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 64'(seen_done), 64'd1);
        chk("done_busy_low", 64'(busy), 64'd0);
        lsk = subkey;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("subkey_hold", 64'(subkey), 64'(m ? ks[1] : ks[16]));
        chk("accept_count", 64'(acc_cnt - base), 64'd16);
        chk("queue_empty", 64'(q.size()), 64'd0);
        if (nostall) chk("busy_cycles", 64'(busy_cyc), 64'd16);
        if (inject) chk("inject_done", 64'(injected), 64'd1);
    endtask

    initial begin
        logic [47:0] f, l;
        logic [63:0] rk;
        int n;
        #12;
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_round", 64'(round), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(KEY, KEY, 1'b0, 1'b1, 1'b0, f, l);
        chk("enc_K1", 64'(f), 64'(K1));
        chk("enc_K16", 64'(l), 64'(K16));

        run(KEY, KEY, 1'b1, 1'b1, 1'b0, f, l);
        chk("dec_first", 64'(f), 64'(K16));
        chk("dec_last", 64'(l), 64'(K1));

        rand_rdy = 1'b1;
        run(KEY, KEY, 1'b0, 1'b0, 1'b0, f, l);
        run(KEY, KEY, 1'b1, 1'b0, 1'b0, f, l);
        rand_rdy = 1'b0;

        run(KEY, KEY, 1'b0, 1'b1, 1'b1, f, l);
        chk("inject_last", 64'(l), 64'(K16));

        // Abort mid-schedule: outputs must clear without waiting for a clock edge.
        build(KEY);
        wait_idle();
        @(posedge clk);
        #1;
        push_exp(1'b0);
        key_in = KEY;
        mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(subkey_valid && round == 4'd9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round9", 64'(round), 64'd9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_round", 64'(round), 64'd0);
        chk("abort_subkey", 64'(subkey), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(KEY, KEY, 1'b0, 1'b1, 1'b0, f, l);
        chk("post_reset_K1", 64'(f), 64'(K1));

        run(KEY ^ 64'h0101010101010101, KEY, 1'b0, 1'b1, 1'b0, f, l);
        chk("parity_K1", 64'(f), 64'(K1));

        rand_rdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rk = {$urandom, $urandom};
            run(rk, rk, 1'($urandom_range(0, 1)), 1'b0, 1'b0, f, l);
        end
        rand_rdy = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
